// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
//  Module   : spi_flash_responder
//  Purpose  : SPI flash target answering the quad-output read command (0x6B).
//             The command and address are shifted in on MOSI. A fixed number
//             of dummy clocks follows. Read data is then returned on IO[3:0],
//             one nibble per SCK falling edge, high nibble first. Any other
//             command is ignored until chip select rises.
//  Ports    : clk          - system clock, all logic on posedge
//             rstn         - synchronous active-low reset
//             spi_clk_in   - SCK from host (asynchronous)
//             spi_select   - chip select, active-low (asynchronous)
//             spi_data_in  - host IO[3:0]; only bit 0 (MOSI) is used
//             spi_data_out - responder IO[3:0] data (0 when not driving)
//             spi_data_oe  - per-bit output enable (1111 only in DATA)
//             mem_addr     - byte address to backing memory
//             mem_rd       - one-cycle read strobe
//             mem_data     - read byte, valid the cycle after mem_rd
//             active       - high while the FSM is not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
   parameter int ADDR_BITS    = 16,
   parameter int DUMMY_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 spi_clk_in,
   input  logic                 spi_select,
   input  logic [3:0]           spi_data_in,
   output logic [3:0]           spi_data_out,
   output logic [3:0]           spi_data_oe,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_rd,
   input  logic [7:0]           mem_data,
   output logic                 active
);

   localparam int CNT_MAX_A = (ADDR_BITS > DUMMY_CYCLES) ? ADDR_BITS : DUMMY_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > 8) ? CNT_MAX_A : 8;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int SH_W      = (ADDR_BITS > 8) ? ADDR_BITS : 8;
   localparam logic [7:0] CMD_QUAD_READ = 8'h6B;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      ADDR   = 3'd2,
      DUMMY  = 3'd3,
      DATA   = 3'd4,
      IGNORE = 3'd5
   } state_t;

   state_t               state_q, state_n;
   logic                 sck_meta, sck_sync, sck_prev;
   logic                 sel_meta, sel_sync, sel_prev;
   logic                 mosi_meta, mosi_sync;
   logic [1:0]           sync_fill;
   logic                 armed;
   logic [CNT_W-1:0]     cnt_q, cnt_n;
   logic [SH_W-2:0]      shift_q, shift_n;
   logic [SH_W-1:0]      shift_in;
   logic [ADDR_BITS-1:0] addr_q, addr_n;
   logic                 rd_q, rd_n, rd_dly;
   logic [7:0]           hold_q;
   logic [3:0]           low_q, low_n;
   logic [3:0]           out_q, out_n;
   logic [3:0]           oe_q;
   logic                 nib_q, nib_n;
   logic                 sck_rise, sck_fall, sel_fall, sel_rise;
   logic                 unused_io;

   assign unused_io = ^spi_data_in[3:1];

   // SCK edges only count while select is (synchronously) low.
   assign sck_rise = sck_sync & ~sck_prev & ~sel_sync;
   assign sck_fall = ~sck_sync & sck_prev & ~sel_sync;
   // The synchronizer resets to "select high", so a select that is already
   // low when reset is released would look like a falling edge. 'armed'
   // requires a real high level to be seen first.
   assign sel_fall = ~sel_sync & sel_prev & armed;
   assign sel_rise = sel_sync & ~sel_prev;

   assign shift_in = {shift_q, mosi_sync};

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sck_meta  <= 1'b0;
         sck_sync  <= 1'b0;
         sck_prev  <= 1'b0;
         sel_meta  <= 1'b1;
         sel_sync  <= 1'b1;
         sel_prev  <= 1'b1;
         mosi_meta <= 1'b0;
         mosi_sync <= 1'b0;
         sync_fill <= 2'b00;
         armed     <= 1'b0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         addr_q    <= '0;
         rd_q      <= 1'b0;
         rd_dly    <= 1'b0;
         hold_q    <= '0;
         low_q     <= '0;
         out_q     <= '0;
         oe_q      <= '0;
         nib_q     <= 1'b0;
      end else begin
         sck_meta  <= spi_clk_in;
         sck_sync  <= sck_meta;
         sck_prev  <= sck_sync;
         sel_meta  <= spi_select;
         sel_sync  <= sel_meta;
         sel_prev  <= sel_sync;
         mosi_meta <= spi_data_in[0];
         mosi_sync <= mosi_meta;
         sync_fill <= {sync_fill[0], 1'b1};
         if (sync_fill[1] && sel_sync) begin
            armed <= 1'b1;
         end
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         shift_q   <= shift_n;
         addr_q    <= addr_n;
         rd_q      <= rd_n;
         rd_dly    <= rd_q;
         // Memory returns data the cycle after the strobe.
         if (rd_dly) begin
            hold_q <= mem_data;
         end
         low_q     <= low_n;
         out_q     <= out_n;
         nib_q     <= nib_n;
         oe_q      <= (state_n == DATA) ? 4'hF : 4'h0;
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      shift_n = shift_q;
      addr_n  = addr_q;
      rd_n    = 1'b0;
      low_n   = low_q;
      out_n   = out_q;
      nib_n   = nib_q;

      if (sel_rise) begin
         // Select rising wins over any coincident SCK edge.
         state_n = IDLE;
         cnt_n   = '0;
         shift_n = '0;
         nib_n   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sel_fall) begin
                  state_n = CMD;
                  cnt_n   = CNT_W'(7);
                  shift_n = '0;
               end
            end
            CMD: begin
               if (sck_rise) begin
                  shift_n = shift_in[SH_W-2:0];
                  if (cnt_q == '0) begin
                     state_n = (shift_in[7:0] == CMD_QUAD_READ) ? ADDR : IGNORE;
                     cnt_n   = CNT_W'(ADDR_BITS - 1);
                  end else begin
                     cnt_n = cnt_q - 1'b1;
                  end
               end
            end
            ADDR: begin
               if (sck_rise) begin
                  shift_n = shift_in[SH_W-2:0];
                  if (cnt_q == '0) begin
                     state_n = DUMMY;
                     addr_n  = shift_in[ADDR_BITS-1:0];
                     rd_n    = 1'b1;
                     cnt_n   = CNT_W'(DUMMY_CYCLES);
                  end else begin
                     cnt_n = cnt_q - 1'b1;
                  end
               end
            end
            DUMMY: begin
               if (sck_rise && (cnt_q != '0)) begin
                  cnt_n = cnt_q - 1'b1;
               end else if (sck_fall && (cnt_q == '0)) begin
                  // First byte is already in hold_q; start the prefetch of
                  // the next one while its high nibble goes out.
                  state_n = DATA;
                  out_n   = hold_q[7:4];
                  low_n   = hold_q[3:0];
                  nib_n   = 1'b1;
                  addr_n  = addr_q + 1'b1;
                  rd_n    = 1'b1;
               end
            end
            DATA: begin
               if (sck_fall) begin
                  if (nib_q) begin
                     out_n = low_q;
                     nib_n = 1'b0;
                  end else begin
                     out_n  = hold_q[7:4];
                     low_n  = hold_q[3:0];
                     nib_n  = 1'b1;
                     addr_n = addr_q + 1'b1;
                     rd_n   = 1'b1;
                  end
               end
            end
            IGNORE: begin
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end

      if (state_n != DATA) begin
         out_n = '0;
      end
   end

   assign spi_data_out = out_q & oe_q;
   assign spi_data_oe  = oe_q;
   assign mem_addr     = addr_q;
   assign mem_rd       = rd_q;
   assign active       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16, meaning the number of address bits shifted in after the command.
REQ-002 SHALL have parameter DUMMY_CYCLES, default 8, meaning the number of SCK cycles between the last address bit and the first data nibble.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port spi_clk_in  input  1  SCK from the host, asynchronous to clk.
REQ-006 SHALL have port spi_select  input  1  chip select, active-low, asynchronous to clk.
REQ-007 SHALL have port spi_data_in  input  4  host IO[3:0]; only bit 0 (MOSI) is used.
REQ-008 SHALL have port spi_data_out  output  4  responder IO[3:0] data.
REQ-009 SHALL have port spi_data_oe  output  4  per-bit output enable for spi_data_out.
REQ-010 SHALL have port mem_addr  output  ADDR_BITS  byte address for the backing memory.
REQ-011 SHALL have port mem_rd  output  1  one-cycle read strobe.
REQ-012 SHALL have port mem_data  input  8  read byte; valid the cycle after mem_rd.
REQ-013 SHALL have port active  output  1  high while state is not IDLE.

Function
REQ-014 SHALL pass spi_clk_in, spi_select and spi_data_in[0] through 2-flop synchronizers; all edge detection uses synchronized values.
REQ-015 SHALL support SCK high and low phases each >= 3 clk periods; faster SCK is out of scope.
REQ-016 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
REQ-017 SHALL leave IDLE for CMD on the synchronized select falling edge; bit counter = 7.
REQ-018 SHALL shift MOSI in MSB first on each synchronized SCK rising edge in CMD and ADDR.
REQ-019 SHALL, after the 8th CMD bit, enter ADDR if the command equals 0x6B, else IGNORE.
REQ-020 SHALL, after ADDR_BITS address bits, enter DUMMY, load mem_addr with the captured address and pulse mem_rd for one cycle.
REQ-021 SHALL, in DUMMY, count DUMMY_CYCLES SCK rising edges; on the following SCK falling edge, enter DATA and drive the high nibble of the fetched byte.
REQ-022 SHALL set spi_data_oe = 4'b1111 in DATA and 4'b0000 in every other state.
REQ-023 SHALL, in DATA, advance one nibble per SCK falling edge: high nibble, then low nibble, then the next byte's high nibble.
REQ-024 SHALL update spi_data_out within 3 clk cycles of the SCK falling edge and hold it stable until the next SCK falling edge.
REQ-025 SHALL, when the high nibble of byte N is driven, increment mem_addr and pulse mem_rd to prefetch byte N+1 into a holding register.
REQ-026 SHALL wrap mem_addr modulo 2^ADDR_BITS: address 0xFFFF (ADDR_BITS=16) is followed by 0x0000.
REQ-027 SHALL stay in DATA while select is low; no maximum transfer length.
REQ-028 SHALL, in IGNORE, ignore SCK and MOSI until select rises.
REQ-029 SHALL, on the synchronized select rising edge in any state, return to IDLE within 3 clk cycles, clear spi_data_oe and discard any partial command, address or byte.
REQ-030 SHALL give select-rise priority over a simultaneous SCK edge.
REQ-031 SHALL ignore SCK edges while select is high.
REQ-032 SHALL drive spi_data_out = 4'b0000 whenever spi_data_oe is 0.

Reset
REQ-033 SHALL, while rstn is low at a clk edge, set state IDLE, spi_data_oe 0, spi_data_out 0, mem_rd 0, mem_addr 0, active 0, counters 0, and clear synchronizer flops to the idle level (select high, SCK low).
REQ-034 SHALL, when reset is asserted mid-transaction, abort it; after rstn rises with select still low, wait for a fresh select falling edge.

Verification
REQ-035 SHALL cover read: memory 0x1234=0xA5, 0x1235=0x3C; host sends 0x6B, addr 0x1234, 8 dummy, 4 nibble clocks -> IO shows A,5,3,C; oe 0xF only in DATA.
REQ-036 SHALL cover wrap: read at 0xFFFF for 2 bytes -> bytes from 0xFFFF then 0x0000; mem_addr wraps to 0x0000.
REQ-037 SHALL cover bad command: 0x03 then 40 SCK cycles -> oe stays 0, mem_rd never pulses, active high until select rises.
REQ-038 SHALL cover abort: select rises after 3 of 16 address bits, then a new 0x6B read at 0x0010 -> correct data from 0x0010.
REQ-039 SHALL cover reset: rstn low for 1 cycle during DATA -> oe 0 by the next cycle; with select held low afterwards, no output until select toggles.
REQ-040 SHALL cover minimum SCK period (3 clk high, 3 clk low) over a 16-byte burst -> every nibble matches the memory model, with one mem_rd per byte.
